alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller sequencing read, execute and writeback.
// Optional: define ALU_ISSUE_TIMEOUT_EN to abort a stalled ALU after 16 WAIT cycles.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [2:0]  opcode,
    input  logic [3:0]  fcode,
    input  logic [4:0]  shamt,
    input  logic [21:0] imm,
    output logic        rf_rd_en,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    output logic        alu_go,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [3:0]  alu_fn,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, READ, EXEC, WAIT, WB
    } state_t;

    state_t      state_q, state_d;
    logic        opi_q, opi_d;
    logic [3:0]  fcode_q, fcode_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [21:0] imm_q, imm_d;
    logic [31:0] inp1_q, inp1_d;
    logic [31:0] inp2_q, inp2_d;
    logic [3:0]  fn_q, fn_d;
    logic [31:0] wbd_q, wbd_d;
    logic        err_q, err_d;
    logic        shift_imm;
`ifdef ALU_ISSUE_TIMEOUT_EN
    logic [4:0]  cnt_q, cnt_d;
`endif

    // Shift-by-immediate functions take shamt in place of rt.
    assign shift_imm = (fcode_q == 4'd4) || (fcode_q == 4'd5) ||
                       (fcode_q == 4'd8);

    // Next-state and strobe decode; operands are visible during EXEC.
    always_comb begin
        state_d   = state_q;
        opi_d     = opi_q;
        fcode_d   = fcode_q;
        shamt_d   = shamt_q;
        imm_d     = imm_q;
        inp1_d    = inp1_q;
        inp2_d    = inp2_q;
        fn_d      = fn_q;
        wbd_d     = wbd_q;
        err_d     = 1'b0;
        iss_ready = 1'b0;
        rf_rd_en  = 1'b0;
        alu_go    = 1'b0;
        wb_en     = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
        cnt_d     = 5'd0;
`endif
        unique case (state_q)
            IDLE: begin
                iss_ready = 1'b1;
                if (iss_valid) begin
                    opi_d   = opcode[0];
                    fcode_d = fcode;
                    shamt_d = shamt;
                    imm_d   = imm;
                    if (opcode[2:1] == 2'b00) begin
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                rf_rd_en = 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                alu_go = 1'b1;
                inp1_d = rsData;
                if (opi_q) begin
                    inp2_d = {{10{imm_q[21]}}, imm_q};
                    fn_d   = 4'd0;
                end else begin
                    inp2_d = shift_imm ? {27'b0, shamt_q} : rtData;
                    fn_d   = fcode_q;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    wbd_d   = alu_result;
                    state_d = WB;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (cnt_q == 5'd15) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
`endif
            end
            WB: begin
                wb_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_inp1 = inp1_d;
    assign alu_inp2 = inp2_d;
    assign alu_fn   = fn_d;
    assign wb_data  = wbd_q;
    assign err      = err_q;

    // State and datapath registers; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            opi_q   <= 1'b0;
            fcode_q <= 4'd0;
            shamt_q <= 5'd0;
            imm_q   <= 22'd0;
            inp1_q  <= 32'd0;
            inp2_q  <= 32'd0;
            fn_q    <= 4'd0;
            wbd_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opi_q   <= opi_d;
            fcode_q <= fcode_d;
            shamt_q <= shamt_d;
            imm_q   <= imm_d;
            inp1_q  <= inp1_d;
            inp2_q  <= inp2_d;
            fn_q    <= fn_d;
            wbd_q   <= wbd_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    // WAIT-cycle counter for the stalled-ALU abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench; the bench plays register file and ALU.
// Honours ALU_ISSUE_TIMEOUT_EN when the design is built with it.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [2:0]  opcode = '0;
    logic [3:0]  fcode = '0;
    logic [4:0]  shamt = '0;
    logic [21:0] imm = '0;
    logic        rf_rd_en;
    logic [31:0] rsData = '0;
    logic [31:0] rtData = '0;
    logic        alu_go;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [3:0]  alu_fn;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = '0;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        err;

    typedef struct {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [3:0]  fn;
        logic [31:0] wb;
    } exp_t;

    exp_t sbq[$];
    int n_vec = 0;
    int n_mis = 0;
    int n_rd = 0;
    int n_go = 0;
    int n_wb = 0;
    int n_er = 0;
    int cyc = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .opcode(opcode), .fcode(fcode), .shamt(shamt), .imm(imm),
        .rf_rd_en(rf_rd_en), .rsData(rsData), .rtData(rtData),
        .alu_go(alu_go), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
        .alu_fn(alu_fn), .alu_done(alu_done), .alu_result(alu_result),
        .wb_en(wb_en), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rf_rd_en) n_rd++;
        if (alu_go)   n_go++;
        if (wb_en)    n_wb++;
        if (err)      n_er++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_inp2(input logic [2:0] op,
        input logic [3:0] fc, input logic [4:0] sh,
        input logic [21:0] im, input logic [31:0] rt);
        if (op == 3'd1) return {{10{im[21]}}, im};
        if (fc == 4'd4 || fc == 4'd5 || fc == 4'd8) return {27'b0, sh};
        return rt;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!iss_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rdy_pre", {31'b0, iss_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [3:0] fc,
        input logic [4:0] sh, input logic [21:0] im,
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [31:0] res, input int dly, input bit early,
        input bit hang);
        exp_t e;
        int   n;
        int   rd0;
        int   c0;
        bit   seen;
        e.i1 = rs;
        e.i2 = mdl_inp2(op, fc, sh, im, rt);
        e.fn = (op == 3'd0) ? fc : 4'd0;
        e.wb = res;
        sbq.push_back(e);
        wait_ready();
        rd0 = n_rd;
        opcode = op; fcode = fc; shamt = sh; imm = im;
        rsData = rs; rtData = rt;
        iss_valid = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        iss_valid = 1'b0;
        opcode = '0; fcode = '0; shamt = '0; imm = '0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (alu_go) seen = 1'b1;
        end
        check("go_seen", {31'b0, seen}, 32'd1);
        if (!seen) return;
        check("go_lat", n, 32'd2);
        check("rd_once", n_rd - rd0, 32'd1);
        e = sbq.pop_front();
        check("inp1", alu_inp1, e.i1);
        check("inp2", alu_inp2, e.i2);
        check("fn", {28'b0, alu_fn}, {28'b0, e.fn});
        alu_done = early;
        alu_result = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        rsData = ~rs;
        rtData = ~rt;
        for (int k = 1; k <= dly; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("hold1", alu_inp1, e.i1);
                check("hold2", alu_inp2, e.i2);
                if (hang) return;
            end
            if (k == dly) begin
                alu_done = 1'b1;
                alu_result = res;
            end
        end
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        alu_result = 32'h0BAD_0BAD;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 6) begin
            @(negedge clk);
            n++;
            if (wb_en) seen = 1'b1;
        end
        check("wb_seen", {31'b0, seen}, 32'd1);
        check("wb_data", wb_data, e.wb);
        @(negedge clk);
        check("wb_1cyc", {31'b0, wb_en}, 32'd0);
        check("rdy_post", {31'b0, iss_ready}, 32'd1);
        check("thru", cyc - c0 + 1, 4 + dly);
    endtask

    task automatic bad_op(input logic [2:0] op);
        int rd0;
        int go0;
        wait_ready();
        rd0 = n_rd;
        go0 = n_go;
        opcode = op;
        iss_valid = 1'b1;
        @(posedge clk);
        #1;
        iss_valid = 1'b0;
        @(negedge clk);
        check("err_pulse", {31'b0, err}, 32'd1);
        check("err_rdy", {31'b0, iss_ready}, 32'd1);
        @(negedge clk);
        check("err_1cyc", {31'b0, err}, 32'd0);
        repeat (4) @(negedge clk);
        check("err_nord", n_rd - rd0, 32'd0);
        check("err_nogo", n_go - go0, 32'd0);
    endtask

    initial begin
        int wb0;
        int er0;
        int k;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [21:0] ri;
        logic [3:0]  rf;
        logic [4:0]  rsh;

        repeat (3) @(negedge clk);
        check("rst_rdy", {31'b0, iss_ready}, 32'd1);
        check("rst_rd", {31'b0, rf_rd_en}, 32'd0);
        check("rst_go", {31'b0, alu_go}, 32'd0);
        check("rst_wb", {31'b0, wb_en}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_i1", alu_inp1, 32'd0);
        check("rst_i2", alu_inp2, 32'd0);
        check("rst_fn", {28'b0, alu_fn}, 32'd0);
        check("rst_wbd", wb_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rel_rdy", {31'b0, iss_ready}, 32'd1);

        wb0 = n_wb;
        alu_done = 1'b1;
        alu_result = 32'h1234_5678;
        repeat (3) @(negedge clk);
        alu_done = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done", n_wb - wb0, 32'd0);

        run_op(3'd0, 4'd1, 5'd0, 22'd0, 32'd5, 32'd7, 32'd12, 1, 0, 0);
        run_op(3'd0, 4'd5, 5'd31, 22'd0, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0001, 2, 1, 0);
        run_op(3'd1, 4'd3, 5'd9, 22'h20_0000, 32'd1, 32'd2,
               32'hFFE0_0001, 1, 0, 0);
        run_op(3'd1, 4'd7, 5'd0, 22'h1F_FFFF, 32'd0, 32'h55,
               32'h001F_FFFF, 3, 0, 0);
        run_op(3'd0, 4'd4, 5'd3, 22'd0, 32'hF0, 32'hAAAA, 32'h0F, 1, 1, 0);
        run_op(3'd0, 4'd8, 5'd16, 22'd0, 32'h1, 32'h2, 32'h9, 2, 0, 0);
        run_op(3'd0, 4'd9, 5'd16, 22'h3FFFFF, 32'h77, 32'hCAFE_F00D,
               32'h42, 1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            ri = 22'($urandom);
            rf = 4'($urandom_range(0, 15));
            rsh = 5'($urandom_range(0, 31));
            run_op(3'($urandom_range(0, 1)), rf, rsh, ri, r1, r2,
                   r1 ^ r2, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                   0);
        end

        bad_op(3'd3);
        bad_op(3'd7);
        bad_op(3'd2);

        wb0 = n_wb;
        run_op(3'd0, 4'd2, 5'd0, 22'd0, 32'h11, 32'h22, 32'h33, 1, 0, 1);
        @(negedge clk);
        check("wait_busy", {31'b0, iss_ready}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rdy", {31'b0, iss_ready}, 32'd1);
        check("arst_i1", alu_inp1, 32'd0);
        check("arst_go", {31'b0, alu_go}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        alu_done = 1'b1;
        alu_result = 32'hFEED_BEEF;
        repeat (3) @(negedge clk);
        alu_done = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_nowb", n_wb - wb0, 32'd0);
        check("arst_wbd", wb_data, 32'd0);

        er0 = n_er;
        run_op(3'd1, 4'd0, 5'd0, 22'd5, 32'h1, 32'h0, 32'h6, 1, 0, 1);
`ifdef ALU_ISSUE_TIMEOUT_EN
        k = 0;
        while (!err && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("to_lat", k, 32'd16);
        check("to_rdy", {31'b0, iss_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("to_nowb", n_wb - wb0, 32'd0);
`else
        k = 0;
        repeat (24) begin
            @(negedge clk);
            k++;
        end
        check("nto_busy", {31'b0, iss_ready}, 32'd0);
        check("nto_noerr", n_er - er0, 32'd0);
        rst = 1'b0;
        #3;
        rst = 1'b1;
`endif
        run_op(3'd0, 4'd6, 5'd0, 22'd0, 32'd100, 32'd200, 32'd300, 1, 0, 0);
        check("sb_empty", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
